// File: rtl/itree_loader_if.sv
// Byte-stream link carrying the serial tree image from the host into the loader.
// The source drives byte_in/byte_valid and holds the byte until byte_ready is seen high.
interface itree_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/itree_loader.sv
// Frames SYNC + payload + XOR checksum into a shadow image and commits it to itree_input.
// load_itree fires the cycle after the checksum byte; byte_ready drops only in the COMMIT cycle.
module itree_loader #(
  parameter int          PAYLOAD_BYTES  = 32,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                         clk,
  input  logic                         reset,
  itree_loader_if.slave                link,
  output logic [8*PAYLOAD_BYTES-1:0]   itree_input,
  output logic                         load_itree,
  output logic                         busy,
  output logic                         checksum_error,
  output logic                         timeout_error,
  output logic [7:0]                   frame_count
);

  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, COMMIT} state_t;

  state_t                     state, state_nxt;
  logic [8*PAYLOAD_BYTES-1:0] shadow;
  logic [IDX_W-1:0]           idx;
  logic [7:0]                 xor_acc;
  logic [GAP_W-1:0]           gap;
  logic                       xfer, last_byte, chk_ok, is_sync, timeout_hit;

  assign xfer      = link.byte_valid & link.byte_ready;
  assign last_byte = (idx == IDX_W'(PAYLOAD_BYTES - 1));
  assign chk_ok    = (link.byte_in == xor_acc);
  assign is_sync   = (link.byte_in == SYNC_BYTE);
  // A transfer in the expiry cycle wins over the timeout.
  assign timeout_hit = ((state == PAYLOAD) || (state == CHECK)) && !xfer &&
                       (gap == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && is_sync) state_nxt = PAYLOAD;
      PAYLOAD: if (xfer && last_byte) state_nxt = CHECK;
               else if (timeout_hit)  state_nxt = IDLE;
      CHECK:   if (xfer)              state_nxt = chk_ok ? COMMIT : IDLE;
               else if (timeout_hit)  state_nxt = IDLE;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    link.byte_ready = (state != COMMIT);
    busy            = (state != IDLE);
    load_itree      = (state == COMMIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      itree_input    <= '0;
      shadow         <= '0;
      idx            <= '0;
      xor_acc        <= '0;
      gap            <= '0;
      frame_count    <= '0;
      checksum_error <= 1'b0;
      timeout_error  <= 1'b0;
    end else begin
      checksum_error <= (state == CHECK) && xfer && !chk_ok;
      timeout_error  <= timeout_hit;
      case (state)
        IDLE: begin
          if (xfer && is_sync) begin
            idx     <= '0;
            xor_acc <= '0;
            gap     <= '0;
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            shadow[{idx, 3'b000} +: 8] <= link.byte_in;
            xor_acc <= xor_acc ^ link.byte_in;
            idx     <= last_byte ? '0 : idx + IDX_W'(1);
            gap     <= '0;
          end else begin
            gap     <= timeout_hit ? '0 : gap + GAP_W'(1);
          end
        end
        CHECK: begin
          if (xfer) begin
            gap <= '0;
            // Image and count are updated on the edge that enters COMMIT.
            if (chk_ok) begin
              itree_input <= shadow;
              frame_count <= frame_count + 8'd1;
            end
          end else begin
            gap <= timeout_hit ? '0 : gap + GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_itree_loader.sv
// Directed bench for itree_loader: good/bad/garbage frames, timeout edges, reset, count wrap.
module tb_itree_loader;
  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] itree_input;
  logic         load_itree, busy, checksum_error, timeout_error;
  logic [7:0]   frame_count;

  itree_loader_if link ();

  itree_loader dut (
    .clk            (clk),
    .reset          (reset),
    .link           (link),
    .itree_input    (itree_input),
    .load_itree     (load_itree),
    .busy           (busy),
    .checksum_error (checksum_error),
    .timeout_error  (timeout_error),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_mis = 0;
  int n_load = 0, n_cerr = 0, n_terr = 0, n_overlap = 0, n_badrdy = 0;
  logic [7:0]   pay [32];
  logic [255:0] exp_img;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] img();
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = pay[k];
    return r;
  endfunction

  function automatic logic [7:0] pxor();
    logic [7:0] r = 8'h00;
    for (int k = 0; k < 32; k++) r = r ^ pay[k];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    link.byte_in    = b;
    link.byte_valid = 1'b1;
    while (!link.byte_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("ready_wait", 256'(w), 256'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c);
    send_byte(8'hA5);
    for (int k = 0; k < 32; k++) send_byte(pay[k]);
    send_byte(c);
  endtask

  task automatic idle(input int n);
    link.byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (load_itree)     n_load++;
      if (checksum_error) n_cerr++;
      if (timeout_error)  n_terr++;
      if ((checksum_error && timeout_error) || ((checksum_error || timeout_error) && load_itree))
        n_overlap++;
      if (link.byte_ready == load_itree) n_badrdy++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, base;
    reset = 1'b0;
    link.byte_valid = 1'b0;
    link.byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_itree", itree_input, 256'd0);
    check("rst_load", load_itree, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cerr", checksum_error, 1'b0);
    check("rst_terr", timeout_error, 1'b0);
    check("rst_fc", frame_count, 8'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", link.byte_ready, 1'b1);

    // Good frame 00..1F, checksum 00
    for (int k = 0; k < 32; k++) pay[k] = 8'(k);
    exp_img = img();
    send_frame(8'h00);
    check("good_load", load_itree, 1'b1);
    check("good_lo", itree_input[7:0], 8'h00);
    check("good_hi", itree_input[255:248], 8'h1F);
    check("good_img", itree_input, exp_img);
    check("good_fc", frame_count, 8'd1);
    check("commit_rdy", link.byte_ready, 1'b0);
    check("commit_busy", busy, 1'b1);
    idle(2);
    check("good_load_once", n_load, 1);
    check("good_busy_after", busy, 1'b0);

    // Bad checksum: 32 x 11, checksum 01
    for (int k = 0; k < 32; k++) pay[k] = 8'h11;
    send_frame(8'h01);
    check("bad_cerr", checksum_error, 1'b1);
    check("bad_busy", busy, 1'b0);
    idle(2);
    check("bad_cerr_once", n_cerr, 1);
    check("bad_no_load", n_load, 1);
    check("bad_img", itree_input, exp_img);
    check("bad_fc", frame_count, 8'd1);

    // Garbage then a frame of all-A5 payload
    send_byte(8'h3C);
    check("garb1_busy", busy, 1'b0);
    send_byte(8'h7E);
    check("garb2_busy", busy, 1'b0);
    for (int k = 0; k < 32; k++) pay[k] = 8'hA5;
    exp_img = {32{8'hA5}};
    send_frame(8'h00);
    check("garb_load", load_itree, 1'b1);
    check("garb_img", itree_input, exp_img);
    check("garb_fc", frame_count, 8'd2);
    idle(2);

    // Timeout after 5 payload bytes
    send_byte(8'hA5);
    for (int k = 0; k < 5; k++) send_byte(8'(8'h40 + k));
    link.byte_valid = 1'b0;
    i = 0;
    while (!timeout_error && i < 1200) begin
      @(negedge clk);
      i++;
    end
    check("to_gap", i, 1024);
    check("to_busy", busy, 1'b0);
    check("to_cerr", checksum_error, 1'b0);
    idle(2);
    check("to_once", n_terr, 1);
    check("to_img", itree_input, exp_img);
    check("to_fc", frame_count, 8'd2);

    // Transfer lands exactly in the expiry cycle and must win
    for (int k = 0; k < 32; k++) pay[k] = 8'(k * 3 + 1);
    send_byte(8'hA5);
    for (int k = 0; k < 5; k++) send_byte(pay[k]);
    link.byte_valid = 1'b0;
    repeat (1023) @(negedge clk);
    for (int k = 5; k < 32; k++) send_byte(pay[k]);
    send_byte(pxor());
    check("edge_load", load_itree, 1'b1);
    check("edge_img", itree_input, img());
    check("edge_fc", frame_count, 8'd3);
    idle(2);
    check("edge_no_to", n_terr, 1);

    // Reset mid-frame after 10 payload bytes
    send_byte(8'hA5);
    for (int k = 0; k < 10; k++) send_byte(8'(8'h20 + k));
    link.byte_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_busy", busy, 1'b0);
    check("mid_itree", itree_input, 256'd0);
    check("mid_fc", frame_count, 8'd0);
    check("mid_load", load_itree, 1'b0);
    check("mid_errs", {checksum_error, timeout_error}, 2'b00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(2);
    check("mid_no_cerr", n_cerr, 1);
    check("mid_no_terr", n_terr, 1);
    for (int k = 0; k < 32; k++) pay[k] = 8'(k) ^ 8'h5A;
    send_frame(pxor());
    check("post_rst_load", load_itree, 1'b1);
    check("post_rst_fc", frame_count, 8'd1);
    check("post_rst_img", itree_input, img());
    idle(2);

    // 256 back-to-back frames from a fresh reset: count wraps to 0
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    base = n_load;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 32; k++) pay[k] = 8'(f + 7 * k);
      send_frame(pxor());
      if (f == 254) check("wrap_fc255", frame_count, 8'd255);
    end
    check("wrap_fc0", frame_count, 8'd0);
    check("wrap_img", itree_input, img());
    idle(2);
    check("wrap_loads", n_load - base, 256);
    check("wrap_cerr", n_cerr, 1);
    check("ready_vs_commit", n_badrdy, 0);
    check("err_overlap", n_overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/itree_loader.md
ITREE_LOADER -- requirements
Module: itree_loader

Interface
REQ-001 The block SHALL have parameter PAYLOAD_BYTES, default 32, meaning the tree image size in bytes (256 bits).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum idle gap in cycles between accepted bytes inside a frame.
REQ-003 The block SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame header value.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 byte_in  input  8  serial tree image byte from the host link.
REQ-007 byte_valid  input  1  byte_in holds a byte this cycle.
REQ-008 byte_ready  output  1  block accepts byte_in this cycle; a transfer occurs when byte_valid and byte_ready are both high.
REQ-009 itree_input  output  256  committed tree image for the isolation-tree state machine.
REQ-010 load_itree  output  1  one-cycle strobe: itree_input holds a newly committed image.
REQ-011 busy  output  1  high when a frame is in progress (any state other than IDLE).
REQ-012 checksum_error  output  1  one-cycle pulse: frame rejected on checksum mismatch.
REQ-013 timeout_error  output  1  one-cycle pulse: frame aborted on inter-byte timeout.
REQ-014 frame_count  output  8  number of committed frames, wraps 255 -> 0.

Function
REQ-015 The frame format SHALL be: SYNC_BYTE, then PAYLOAD_BYTES payload bytes, then one checksum byte equal to the XOR of all payload bytes.
REQ-016 The state machine SHALL have states IDLE, PAYLOAD, CHECK, COMMIT.
- IDLE: accepted byte == SYNC_BYTE -> PAYLOAD, clear byte index and running XOR; any other accepted byte discarded, stay IDLE.
- PAYLOAD: each accepted byte k (k = 0 first) written to shadow bits [8k+7:8k], XOR updated; after byte PAYLOAD_BYTES-1 -> CHECK.
- CHECK: accepted byte == running XOR -> COMMIT; mismatch -> IDLE with checksum_error pulse the following cycle.
- COMMIT: lasts exactly one cycle, then IDLE.
REQ-017 In PAYLOAD, a byte equal to SYNC_BYTE SHALL be treated as payload data, not as a new header.
REQ-018 byte_ready SHALL be high in IDLE, PAYLOAD and CHECK and low in COMMIT.
REQ-019 On entry to COMMIT, itree_input SHALL be loaded from the shadow register and load_itree SHALL be high for exactly that one cycle.
REQ-020 Latency: load_itree SHALL assert on the cycle after the checksum byte is accepted.
REQ-021 itree_input SHALL change only in COMMIT; rejected or aborted frames SHALL leave itree_input and frame_count unchanged.
REQ-022 frame_count SHALL increment by 1 in COMMIT, modulo 256.
REQ-023 A gap counter SHALL clear on each accepted byte and on PAYLOAD entry, increment each cycle in PAYLOAD or CHECK without a transfer, and on reaching TIMEOUT_CYCLES force IDLE with timeout_error pulsed for one cycle.
REQ-024 If a transfer and the timeout occur in the same cycle, the transfer SHALL win and the gap counter clear.
REQ-025 A byte presented while byte_ready is low SHALL not be consumed; the source holds it until accepted.
REQ-026 checksum_error and timeout_error SHALL never assert together, and neither SHALL assert in the same cycle as load_itree.

Reset
REQ-027 While reset is low: state IDLE, itree_input 0, shadow 0, load_itree 0, busy 0, checksum_error 0, timeout_error 0, frame_count 0, gap counter 0, byte index 0, XOR 0; byte_ready SHALL be 1 once reset deasserts.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame immediately, with no error pulse.

Verification
REQ-029 Good frame: A5, bytes 00..1F, checksum 00 -> load_itree one cycle after checksum, itree_input[7:0]=00, [255:248]=1F, frame_count=1.
REQ-030 Bad checksum: A5, 32 x 11, checksum 01 -> checksum_error one pulse, no load_itree, itree_input and frame_count unchanged.
REQ-031 Garbage then frame: 3C, 7E, A5, 32 x A5, checksum 00 -> leading bytes discarded, A5 payload bytes stored, itree_input = all A5, load_itree pulses.
REQ-032 Timeout: A5, 5 payload bytes, byte_valid low for 1024 cycles -> timeout_error pulse, busy 0; a new full frame then commits normally.
REQ-033 Backpressure/wrap: 256 back-to-back good frames with byte_valid held high -> byte_ready low only in each COMMIT cycle, no byte lost, frame_count wraps to 0.
REQ-034 Reset mid-frame: reset low after 10 payload bytes -> all outputs at reset values, no error pulse, next good frame commits with frame_count=1.
